// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register map, bit indices, FSM states.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_BAUD   = 2'd3;

    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_RX_FULL  = 1;
    localparam int unsigned ST_TX_BUSY  = 2;
    localparam int unsigned ST_OVR      = 3;
    localparam int unsigned ST_TX_DROP  = 4;

    localparam int unsigned CTRL_RX_EN  = 0;
    localparam int unsigned CTRL_TX_EN  = 1;
    localparam int unsigned CTRL_IRQ_RX = 2;
    localparam int unsigned CTRL_IRQ_TX = 3;

    localparam logic [15:0] DIV_RST_DEF = 16'd434;

    typedef enum logic [2:0] {
        IDLE,
        RD_POP,
        TX_WAIT,
        TX_HOLD,
        ACK
    } state_t;

endpackage

// File: rtl/uart_bus_ctrl.sv
// CPU bus front end for the UART: register file plus sequencing FSM.
// UART_IRQ_EN adds CTRL[3:2] interrupt masks and the registered IRQ output.
module uart_bus_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned      DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RST_DEF)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BUS_SEL,
    input  logic             BUS_WE,
    input  logic [1:0]       BUS_ADDR,
    input  logic [7:0]       BUS_WDATA,
    output logic [7:0]       BUS_RDATA,
    output logic             BUS_READY,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_EMPTY,
    input  logic             RX_PUSH,
    input  logic             RX_FULL,
    output logic             RX_POP,
    output logic [7:0]       TX_DATA,
    output logic             TX_START,
    input  logic             TX_BUSY,
    output logic [DIV_W-1:0] BAUD_DIV,
    output logic             RX_EN,
    output logic             TX_EN
`ifdef UART_IRQ_EN
    ,
    output logic             IRQ
`endif
);

`ifdef UART_IRQ_EN
    localparam int unsigned CTRL_W = 4;
`else
    localparam int unsigned CTRL_W = 2;
`endif

    state_t            state_q;
    logic [7:0]        rdata_q;
    logic [7:0]        tx_data_q;
    logic              ready_q;
    logic              rx_pop_q;
    logic              tx_start_q;
    logic              tx_drop_q;
    logic              ovr_q;
    logic              ptr_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DIV_W-1:0]  baud_q;
    logic [DIV_W-1:0]  baud_d;
    logic [7:0]        status;
    logic [7:0]        reg_rdata;
    logic              ovr_clr;

    assign status  = {3'b000, tx_drop_q, ovr_q, TX_BUSY, RX_FULL, RX_EMPTY};
    assign ovr_clr = (state_q == IDLE) && BUS_SEL && BUS_WE &&
                     (BUS_ADDR == ADDR_STATUS) && BUS_WDATA[ST_OVR];

    always_comb begin
        baud_d = baud_q;
        if (ptr_q) baud_d[DIV_W-1:8] = BUS_WDATA[DIV_W-9:0];
        else       baud_d[7:0]       = BUS_WDATA;
        if (baud_d < DIV_W'(2)) baud_d = DIV_W'(2);
    end

    always_comb begin
        reg_rdata = '0;
        case (BUS_ADDR)
            ADDR_STATUS: reg_rdata = status;
            ADDR_CTRL:   reg_rdata = 8'(ctrl_q);
            ADDR_BAUD:   reg_rdata = ptr_q ? 8'(baud_q >> 8) : baud_q[7:0];
            default:     reg_rdata = '0;
        endcase
    end

    // ACK owns BUS_READY; RD_POP and TX_HOLD raise it on the way in, so ACK
    // only spends an extra cycle raising it for paths that arrive straight from IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            tx_data_q  <= '0;
            ready_q    <= 1'b0;
            rx_pop_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_drop_q  <= 1'b0;
            ovr_q      <= 1'b0;
            ptr_q      <= 1'b0;
            ctrl_q     <= '0;
            baud_q     <= DIV_RST;
        end else begin
            ready_q    <= 1'b0;
            rx_pop_q   <= 1'b0;
            tx_start_q <= 1'b0;
            if (RX_PUSH && RX_FULL) ovr_q <= 1'b1;
            else if (ovr_clr)       ovr_q <= 1'b0;

            unique case (state_q)
                IDLE: if (BUS_SEL) begin
                    if (BUS_ADDR == ADDR_DATA) begin
                        if (BUS_WE) begin
                            if (ctrl_q[CTRL_TX_EN]) begin
                                state_q <= TX_WAIT;
                            end else begin
                                tx_drop_q <= 1'b1;
                                state_q   <= ACK;
                            end
                        end else if (!RX_EMPTY) begin
                            state_q <= RD_POP;
                        end else begin
                            rdata_q <= '0;
                            state_q <= ACK;
                        end
                    end else begin
                        if (BUS_WE) begin
                            case (BUS_ADDR)
                                ADDR_STATUS: if (BUS_WDATA[ST_TX_DROP]) tx_drop_q <= 1'b0;
                                ADDR_CTRL:   ctrl_q <= BUS_WDATA[CTRL_W-1:0];
                                ADDR_BAUD: begin
                                    baud_q <= baud_d;
                                    ptr_q  <= ~ptr_q;
                                end
                                default: ;
                            endcase
                        end else begin
                            rdata_q <= reg_rdata;
                        end
                        state_q <= ACK;
                    end
                end
                RD_POP: begin
                    rdata_q  <= RX_DATA;
                    rx_pop_q <= !RX_EMPTY;
                    ready_q  <= 1'b1;
                    state_q  <= ACK;
                end
                TX_WAIT: if (!TX_BUSY) begin
                    tx_data_q  <= BUS_WDATA;
                    tx_start_q <= 1'b1;
                    state_q    <= TX_HOLD;
                end
                TX_HOLD: begin
                    ready_q <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    if (ready_q) state_q <= IDLE;
                    else         ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    logic irq_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) irq_q <= 1'b0;
        else        irq_q <= (ctrl_q[CTRL_IRQ_RX] && !RX_EMPTY) ||
                             (ctrl_q[CTRL_IRQ_TX] && !TX_BUSY && ctrl_q[CTRL_TX_EN]) ||
                             ovr_q;
    end

    assign IRQ = irq_q;
`endif

    assign BUS_RDATA = rdata_q;
    assign BUS_READY = ready_q;
    assign RX_POP    = rx_pop_q;
    assign TX_DATA   = tx_data_q;
    assign TX_START  = tx_start_q;
    assign BAUD_DIV  = baud_q;
    assign RX_EN     = ctrl_q[CTRL_RX_EN];
    assign TX_EN     = ctrl_q[CTRL_TX_EN];

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl: bus transactions against hand-computed expectations.
module tb_uart_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        bwe = 1'b0;
    logic [1:0]  baddr = '0;
    logic [7:0]  bwd = '0;
    logic [7:0]  rdata;
    logic        ready;
    logic [7:0]  rx_data = '0;
    logic        rx_empty = 1'b1;
    logic        rx_push = 1'b0;
    logic        rx_full = 1'b0;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [15:0] baud;
    logic        rx_en;
    logic        tx_en;
`ifdef UART_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    uart_bus_ctrl #(.DIV_W(16), .DIV_RST(16'd434)) dut (
        .CLK(clk), .RST_N(rst_n),
        .BUS_SEL(sel), .BUS_WE(bwe), .BUS_ADDR(baddr), .BUS_WDATA(bwd),
        .BUS_RDATA(rdata), .BUS_READY(ready),
        .RX_DATA(rx_data), .RX_EMPTY(rx_empty), .RX_PUSH(rx_push), .RX_FULL(rx_full),
        .RX_POP(rx_pop), .TX_DATA(tx_data), .TX_START(tx_start), .TX_BUSY(tx_busy),
        .BAUD_DIV(baud), .RX_EN(rx_en), .TX_EN(tx_en)
`ifdef UART_IRQ_EN
        , .IRQ(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; drives one request, counts strobes until READY, then checks the pulse ends.
    task automatic bus_xfer(input string tag, input logic we, input logic [1:0] addr,
                            input logic [7:0] wd, output logic [7:0] rd, output int lat,
                            output int pops, output int starts, output logic [7:0] txd);
        logic done;
        done = 1'b0; lat = 0; pops = 0; starts = 0; txd = '0; rd = '0;
        sel = 1'b1; bwe = we; baddr = addr; bwd = wd;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rx_pop) pops++;
            if (tx_start) begin starts++; txd = tx_data; end
            if (ready) begin rd = rdata; done = 1'b1; end
        end
        sel = 1'b0; bwe = 1'b0;
        check_eq({tag, "_ready_seen"}, 32'(done), 1);
        @(posedge clk); #1;
        if (rx_pop) pops++;
        check_eq({tag, "_ready_pulse"}, 32'(ready), 0);
    endtask

    logic [7:0] rd;
    logic [7:0] txd;
    int lat, pops, starts, seen;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check_eq("rst_baud", 32'(baud), 434);
        check_eq("rst_ready", 32'(ready), 0);
        check_eq("rst_pop", 32'(rx_pop), 0);
        check_eq("rst_start", 32'(tx_start), 0);
        check_eq("rst_txdata", 32'(tx_data), 0);
        check_eq("rst_rdata", 32'(rdata), 0);
        check_eq("rst_ctrl", 32'({tx_en, rx_en}), 0);
        bus_xfer("st0", 1'b0, 2'd1, 8'h00, rd, lat, pops, starts, txd);
        check_eq("st0_val", 32'(rd), 32'h01);
        check_eq("st0_lat", 32'(lat), 2);

        bus_xfer("drop", 1'b1, 2'd0, 8'h55, rd, lat, pops, starts, txd);
        check_eq("drop_start", 32'(starts), 0);
        check_eq("drop_lat", 32'(lat), 2);
        bus_xfer("st1", 1'b0, 2'd1, 8'h00, rd, lat, pops, starts, txd);
        check_eq("st1_txdrop", 32'(rd), 32'h11);
        bus_xfer("w1c", 1'b1, 2'd1, 8'h10, rd, lat, pops, starts, txd);
        bus_xfer("st2", 1'b0, 2'd1, 8'h00, rd, lat, pops, starts, txd);
        check_eq("st2_cleared", 32'(rd), 32'h01);

        rx_data = 8'hA5; rx_empty = 1'b0;
        bus_xfer("rxa5", 1'b0, 2'd0, 8'h00, rd, lat, pops, starts, txd);
        check_eq("rxa5_data", 32'(rd), 32'hA5);
        check_eq("rxa5_pops", 32'(pops), 1);
        check_eq("rxa5_lat", 32'(lat), 2);

        rx_data = 8'h77; rx_empty = 1'b1;
        bus_xfer("rxemp", 1'b0, 2'd0, 8'h00, rd, lat, pops, starts, txd);
        check_eq("rxemp_data", 32'(rd), 32'h00);
        check_eq("rxemp_pops", 32'(pops), 0);
        check_eq("rxemp_lat", 32'(lat), 2);

        bus_xfer("ctrl", 1'b1, 2'd2, 8'h03, rd, lat, pops, starts, txd);
        check_eq("ctrl_en", 32'({tx_en, rx_en}), 32'h3);
        bus_xfer("ctrlrd", 1'b0, 2'd2, 8'h00, rd, lat, pops, starts, txd);
        check_eq("ctrlrd_val", 32'(rd), 32'h03);

        tx_busy = 1'b1;
        fork
            begin
                repeat (10) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
            bus_xfer("tx", 1'b1, 2'd0, 8'h3C, rd, lat, pops, starts, txd);
        join
        check_eq("tx_lat", 32'(lat), 12);
        check_eq("tx_starts", 32'(starts), 1);
        check_eq("tx_data", 32'(txd), 32'h3C);
        check_eq("tx_data_hold", 32'(tx_data), 32'h3C);

        bus_xfer("bd_lo", 1'b1, 2'd3, 8'h10, rd, lat, pops, starts, txd);
        check_eq("bd_lo_val", 32'(baud), 32'h0110);
        bus_xfer("bd_rdhi", 1'b0, 2'd3, 8'h00, rd, lat, pops, starts, txd);
        check_eq("bd_rdhi_val", 32'(rd), 32'h01);
        bus_xfer("bd_hi", 1'b1, 2'd3, 8'h00, rd, lat, pops, starts, txd);
        check_eq("bd_hi_val", 32'(baud), 32'h0010);
        bus_xfer("bd_rdlo", 1'b0, 2'd3, 8'h00, rd, lat, pops, starts, txd);
        check_eq("bd_rdlo_val", 32'(rd), 32'h10);
        bus_xfer("bd_clamp", 1'b1, 2'd3, 8'h01, rd, lat, pops, starts, txd);
        check_eq("bd_clamp_val", 32'(baud), 32'h0002);
        bus_xfer("bd_hi0", 1'b1, 2'd3, 8'h00, rd, lat, pops, starts, txd);
        check_eq("bd_hi0_val", 32'(baud), 32'h0002);

        rx_push = 1'b1; rx_full = 1'b1;
        @(posedge clk); #1;
        rx_push = 1'b0; rx_full = 1'b0;
        bus_xfer("ovr", 1'b0, 2'd1, 8'h00, rd, lat, pops, starts, txd);
        check_eq("ovr_set", 32'(rd), 32'h09);
        rx_push = 1'b1; rx_full = 1'b1;
        bus_xfer("ovr_race", 1'b1, 2'd1, 8'h08, rd, lat, pops, starts, txd);
        rx_push = 1'b0; rx_full = 1'b0;
        bus_xfer("ovr2", 1'b0, 2'd1, 8'h00, rd, lat, pops, starts, txd);
        check_eq("ovr_setwins", 32'(rd), 32'h09);
        bus_xfer("ovr_clr", 1'b1, 2'd1, 8'h18, rd, lat, pops, starts, txd);
        bus_xfer("ovr3", 1'b0, 2'd1, 8'h00, rd, lat, pops, starts, txd);
        check_eq("ovr_cleared", 32'(rd), 32'h01);

        tx_busy = 1'b1; seen = 0;
        sel = 1'b1; bwe = 1'b1; baddr = 2'd0; bwd = 8'h99;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready || tx_start) seen++;
        end
        rst_n = 1'b0;
        #1 check_eq("rst_async_baud", 32'(baud), 434);
        repeat (2) begin
            @(posedge clk); #1;
            if (ready || tx_start) seen++;
        end
        sel = 1'b0; bwe = 1'b0; rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready || tx_start) seen++;
        end
        check_eq("rst_mid_none", 32'(seen), 0);
        check_eq("rst_mid_txen", 32'(tx_en), 0);
        tx_busy = 1'b0;
        bus_xfer("post", 1'b0, 2'd1, 8'h00, rd, lat, pops, starts, txd);
        check_eq("post_status", 32'(rd), 32'h01);
        check_eq("post_lat", 32'(lat), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
